// File: rtl/rv_muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: funct3 op codes,
// controller states and the datapath writeback-select code for its result.
package rv_muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  // Next free code in the datapath wbsel mux, routes o_result to the register file
  localparam logic [2:0] WB_MULDIV = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic rs1_signed(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic rs2_signed(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/rv_muldiv.sv
// Iterative RV32M/RV64M multiply/divide: one bit per cycle, shift-add multiply
// and restoring divide sharing one accumulator and counter.
module rv_muldiv
  import rv_muldiv_pkg::*;
#(
  parameter  int DPWIDTH = 32,
  localparam int CNTW    = $clog2(DPWIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_kill,
  input  logic [2:0]         i_op,
  input  logic [DPWIDTH-1:0] i_rs1,
  input  logic [DPWIDTH-1:0] i_rs2,
  output logic               o_busy,
  output logic               o_done,
  output logic [DPWIDTH-1:0] o_result
);

  localparam int W = DPWIDTH;
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic [W-1:0]     r_result;
  logic [2:0]       r_op;
  logic             r_s1;
  logic             r_neg;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [2*W-1:0]   r_acc;
  logic [CNTW-1:0]  r_cnt;

  logic             w_s1;
  logic             w_s2;
  logic [W-1:0]     w_mag1;
  logic [W-1:0]     w_mag2;
  logic             w_zero;
  logic             w_ovf;
  logic             w_special;
  logic [W-1:0]     w_spec_res;

  assign w_s1       = rs1_signed(i_op) & i_rs1[W-1];
  assign w_s2       = rs2_signed(i_op) & i_rs2[W-1];
  assign w_mag1     = w_s1 ? -i_rs1 : i_rs1;
  assign w_mag2     = w_s2 ? -i_rs2 : i_rs2;
  assign w_zero     = (i_rs2 == '0);
  assign w_ovf      = ~i_op[0] & (i_rs1 == MIN_NEG) & (i_rs2 == '1);
  assign w_special  = i_op[2] & (w_zero | w_ovf);
  // op[1] separates REM/REMU from DIV/DIVU inside the divide group
  assign w_spec_res = i_op[1] ? (w_zero ? i_rs1 : '0) : (w_zero ? '1 : i_rs1);

  logic [W:0]       w_sum;
  logic [W:0]       w_rem_sh;
  logic             w_ge;
  logic [W-1:0]     w_diff;
  logic [2*W-1:0]   w_acc_nxt;

  // Multiply: acc = {partial high, remaining multiplier}, shifted right each step.
  // Divide: acc = {remainder, dividend bits / quotient bits}, shifted left each step.
  assign w_sum     = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_a} : '0);
  assign w_rem_sh  = r_acc[2*W-1:W-1];
  assign w_ge      = (w_rem_sh >= {1'b0, r_b});
  assign w_diff    = w_rem_sh[W-1:0] - r_b;
  assign w_acc_nxt = r_op[2] ? (w_ge ? {w_diff, r_acc[W-2:0], 1'b1}
                                     : {r_acc[2*W-2:0], 1'b0})
                             : {w_sum, r_acc[W-1:1]};

  logic [2*W-1:0]   w_prod;
  logic [W-1:0]     w_quo;
  logic [W-1:0]     w_rem;
  logic [W-1:0]     w_fix;

  assign w_prod = r_neg ? -r_acc : r_acc;
  assign w_quo  = r_neg ? -r_acc[W-1:0] : r_acc[W-1:0];
  assign w_rem  = r_s1 ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];
  assign w_fix  = r_op[2] ? (r_op[1] ? w_rem : w_quo)
                          : ((r_op[1:0] == 2'b00) ? w_prod[W-1:0] : w_prod[2*W-1:W]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_op     <= '0;
      r_s1     <= 1'b0;
      r_neg    <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (i_kill) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
          if (i_start) begin
            r_op  <= i_op;
            r_s1  <= w_s1;
            r_neg <= w_s1 ^ w_s2;
            r_a   <= w_mag1;
            r_b   <= w_mag2;
            r_cnt <= '0;
            if (w_special) begin
              r_result <= w_spec_res;
              r_done   <= 1'b1;
              r_state  <= DONE;
            end else begin
              r_acc   <= {{W{1'b0}}, (i_op[2] ? w_mag1 : w_mag2)};
              r_busy  <= 1'b1;
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNTW'(W - 1)) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          r_result <= w_fix;
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
          r_state  <= DONE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_result = r_result;

endmodule

// File: tb/tb_rv_muldiv.sv
// Scoreboard bench for rv_muldiv: stimulus pushes expected result and done
// cycle from an arithmetic reference model; a monitor pops on every done pulse.
module tb_rv_muldiv;

  localparam int W = 32;
  localparam int LAT_NORM = W + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_start = 1'b0;
  logic         i_kill = 1'b0;
  logic [2:0]   i_op = '0;
  logic [W-1:0] i_rs1 = '0;
  logic [W-1:0] i_rs2 = '0;
  logic         o_busy;
  logic         o_done;
  logic [W-1:0] o_result;

  rv_muldiv #(.DPWIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_start  (i_start),
    .i_kill   (i_kill),
    .i_op     (i_op),
    .i_rs1    (i_rs1),
    .i_rs2    (i_rs2),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_result (o_result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] res;
    int           due;
    logic [2:0]   op;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         mon_e;
  logic [W-1:0] last_res = '0;

  function automatic bit ref_special(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    if (op < 3'd4) return 1'b0;
    if (b == '0) return 1'b1;
    return ((op == 3'd4) || (op == 3'd6)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [W-1:0] ref_res(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint       sa, sbv, ua, ub;
    logic [63:0]  p;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ua  = longint'({32'b0, a});
    ub  = longint'({32'b0, b});
    p   = '0;
    if (op >= 3'd4 && b == '0)
      return (op[1]) ? a : 32'hFFFF_FFFF;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return (op == 3'd4) ? a : 32'h0;
    case (op)
      3'd0: begin p = sa * sbv; return p[31:0];  end
      3'd1: begin p = sa * sbv; return p[63:32]; end
      3'd2: begin p = sa * ub;  return p[63:32]; end
      3'd3: begin p = ua * ub;  return p[63:32]; end
      3'd4: begin p = sa / sbv; return p[31:0];  end
      3'd5: begin p = ua / ub;  return p[31:0];  end
      3'd6: begin p = sa % sbv; return p[31:0];  end
      default: begin p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && o_done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got result %h at cycle %0d expected no done", o_result, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("result", o_result, mon_e.res);
        check_i("done_cycle", cyc, mon_e.due);
      end
    end
  end

  // Entered and left on a falling edge; start is sampled at the next rising edge.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit track);
    int   guard;
    exp_t e;
    guard = 0;
    while (o_busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: busy still %b after %0d cycles expected 0", o_busy, guard);
    end
    i_start = 1'b1;
    i_op    = op;
    i_rs1   = a;
    i_rs2   = b;
    if (track) begin
      e.res = ref_res(op, a, b);
      e.op  = op;
      e.due = cyc + 1 + (ref_special(op, a, b) ? 0 : LAT_NORM);
      exp_q.push_back(e);
      last_res = e.res;
    end
    @(negedge clk);
    i_start = 1'b0;
    i_op    = 3'($urandom);
    i_rs1   = $urandom;
    i_rs2   = $urandom;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (o_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int           n;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    int           r;

    repeat (3) @(negedge clk);
    check("reset_busy", {31'b0, o_busy}, 32'h0);
    check("reset_done", {31'b0, o_done}, 32'h0);
    check("reset_result", o_result, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // First MUL also measures the busy window
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b1);
    n = 0;
    while (o_busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check_i("busy_cycles", n, 33);

    issue(3'd1, 32'h8000_0000, 32'h8000_0000, 1'b1);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b1);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b1);
    issue(3'd5, 32'd100, 32'd7, 1'b1);
    issue(3'd7, 32'd100, 32'd7, 1'b1);
    issue(3'd5, 32'd5, 32'd0, 1'b1);
    issue(3'd7, 32'd5, 32'd0, 1'b1);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);

    // start held high with changing operands while busy must be ignored
    issue(3'd0, $urandom, $urandom, 1'b1);
    repeat (10) begin
      i_start = 1'b1;
      i_op    = 3'($urandom);
      i_rs1   = $urandom;
      i_rs2   = $urandom;
      @(negedge clk);
    end
    i_start = 1'b0;

    // back-to-back: second start lands in the DONE cycle of the first
    issue(3'd0, $urandom, $urandom, 1'b1);
    issue(3'd0, $urandom, $urandom, 1'b1);

    // kill at CALC count 10, then restart on the following cycle
    issue(3'd0, 32'h1234_5678, 32'h0BAD_F00D, 1'b0);
    repeat (10) @(negedge clk);
    i_kill = 1'b1;
    @(negedge clk);
    i_kill = 1'b0;
    check("kill_busy", {31'b0, o_busy}, 32'h0);
    check("kill_done", {31'b0, o_done}, 32'h0);
    check("kill_result", o_result, last_res);
    issue(3'd5, 32'hDEAD_BEEF, 32'd13, 1'b1);

    // kill and start together: request dropped
    wait_idle();
    @(negedge clk);
    i_start = 1'b1;
    i_kill  = 1'b1;
    i_op    = 3'd0;
    i_rs1   = 32'd3;
    i_rs2   = 32'd3;
    @(negedge clk);
    i_start = 1'b0;
    i_kill  = 1'b0;
    check("kill_start_busy", {31'b0, o_busy}, 32'h0);
    check("kill_start_done", {31'b0, o_done}, 32'h0);

    for (int k = 0; k < 60; k++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      r  = $urandom_range(0, 9);
      if (r == 0) b = '0;
      else if (r == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (r == 2) b = 32'hFFFF_FFFF;
      else if (r == 3) b = 32'($urandom_range(1, 15));
      issue(op, a, b, 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // asynchronous reset in the middle of CALC
    issue(3'd0, $urandom, $urandom, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_busy", {31'b0, o_busy}, 32'h0);
    check("rst_done", {31'b0, o_done}, 32'h0);
    check("rst_result", o_result, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(3'd6, 32'hFFFF_FF00, 32'd7, 1'b1);

    wait_idle();
    repeat (3) @(negedge clk);
    check_i("pending_done", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
